instr_enc: RTL and testbench
============================

# instr_enc

Pipelined RV32I instruction encoder: packs opcode, register, funct and immediate fields into a 32-bit instruction word, scattering the immediate per format (I/S/B/U/J/R). It is the inverse of `imm_gen`, using the same format codes. It feeds the instruction-memory loader and the self-check path, where encoded words are round-tripped through the decoder. Valid/ready on both sides, 2-stage pipeline, optional immediate range checking.

## Interface
- `ERR_CNT_W`, default 16: width of the saturating error counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input fields valid.
- `in_ready` out 1: encoder accepts this cycle.
- `fmt` in 3: I=000, S=001, B=010, U=011, J=100, R=101; 110/111 invalid.
- `opcode` in 7, `rd` in 5, `rs1` in 5, `rs2` in 5, `funct3` in 3, `funct7` in 7: instruction fields.
- `imm` in 32: byte-offset immediate, two's complement (U: full value with low 12 bits as data).
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_instr` out 32: encoded word.
- `out_err` out 1: invalid `fmt` or immediate out of range; qualified by `out_valid`.
- `err_count` out ERR_CNT_W: errored words delivered since reset, saturating.

## Operation
- Encodings:
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
- Fields unused by a format are ignored. I-type shifts carry funct7 in `imm[11:5]`; the caller supplies it there.
- Invalid `fmt`: `out_instr` = 0, `out_err` = 1.
- Stage 1 registers the inputs. Stage 2 encodes and checks, then registers `out_instr`/`out_err`.
- Single pipeline enable `adv = !out_valid || out_ready`; both stages shift together when `adv` is high.
- `in_ready = adv && !rst`. A transfer occurs when `in_valid && in_ready`.
- Stage-1 valid bubbles propagate. `out_valid` reflects stage-2 occupancy.
- `err_count` increments when `out_valid && out_ready && out_err`. It holds at all-ones; no wrap.

## Timing
- Latency: 2 cycles from input handshake to `out_valid` with no backpressure. Throughput is 1 word/cycle.
- While `out_valid && !out_ready`: `out_instr` and `out_err` are held stable, `in_ready` = 0, and no data is lost or reordered.
- Input accepted in the same cycle as an output is consumed: both happen; the pipeline advances.
- Reset values (asynchronous assert): `out_valid` 0, `out_instr` 0, `out_err` 0, `err_count` 0, both stage valids 0. `in_ready` is 0 while `rst` is high.
- Reset mid-operation discards all in-flight words. Nothing is emitted after deassert until new input arrives.

## Configuration
- `INSTR_ENC_RANGE_CHECK_EN` defined: `out_err` = 1 when the immediate does not fit its format:
  - I/S: imm ∉ [-2048, 2047]
  - B: imm ∉ [-4096, 4094] or imm[0] ≠ 0
  - J: imm ∉ [-2^20, 2^20-2] or imm[0] ≠ 0
  - U: imm[11:0] ≠ 0
  - The word is still encoded from the truncated bits.
- Undefined: no range logic. `out_err` is set only for invalid `fmt`. Immediates are silently truncated.

## Structure
- Package `imm_pkg`: `imm_fmt_e` enum (I/S/B/U/J/R codes above), opcode localparams (OP_IMM, LUI, JAL, BRANCH, STORE, OP), shared by `imm_gen`, `instr_enc` and benches.
- Sub-module `imm_range_chk`: combinational, (`fmt`, `imm`) -> `range_err`. Instantiated only under `INSTR_ENC_RANGE_CHECK_EN`.

## Test plan
- I-type: fmt=000, op=0x13, rd=7, f3=2, rs1=10, imm=0x7F3 -> `out_instr`=0x7F352393, err=0, 2 cycles after accept.
- J-type: fmt=100, op=0x6F, rd=1, imm=-4 -> 0xFFDFF0EF. U-type: fmt=011, op=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
- Range check (macro on): B fmt, imm=3 -> err=1, `err_count`=1. I fmt, imm=2048 -> err=1. Macro off, same stimulus -> err=0. fmt=111 -> instr=0, err=1 in both builds.
- Backpressure: `out_ready`=0 for 4 cycles while pushing 3 words -> `in_ready` drops after 2 accepts; all 3 words emerge in order, `out_instr` stable while stalled.
- Reset mid-flight: assert `rst` with 2 words in the pipe -> `out_valid`=0 immediately; no stale word after deassert.
- Round-trip: 1000 random (fmt, imm) pairs within range -> the `imm_gen` decode of `out_instr` equals `imm` (U: imm[31:12]<<12).

Source files
------------

// File: rtl/imm_pkg.sv
// Shared RV32I immediate-format definitions for imm_gen, instr_enc and benches.
// Contents: imm_fmt_e format codes, base opcodes, and the encoder request struct.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_U = 3'b011,
        FMT_J = 3'b100,
        FMT_R = 3'b101
    } imm_fmt_e;

    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] OP     = 7'h33;

    // Raw instruction fields as captured by the first pipeline stage.
    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_req_t;

endpackage

// File: rtl/instr_enc_if.sv
// Handshake bundle for instr_enc.
// Input side: in_valid/in_ready plus the instruction fields.
// Output side: out_valid/out_ready, out_instr, out_err.
// slave = encoder view, master = producer/consumer view.
interface instr_enc_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/imm_range_chk.sv
// Combinational immediate range check: flags an immediate that does not fit
// the selected format. Ports: fmt (format code), imm (32-bit immediate),
// range_err (1 = does not fit). Invalid formats are not flagged here.
module imm_range_chk
    import imm_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic        range_err
);
    // A signed value fits N bits when all bits from N-1 upward are equal.
    logic fits12, fits13, fits21;
    assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        range_err = 1'b0;
        case (fmt)
            FMT_I, FMT_S: range_err = !fits12;
            FMT_B:        range_err = !fits13 || imm[0];
            FMT_J:        range_err = !fits21 || imm[0];
            FMT_U:        range_err = |imm[11:0];
            default:      range_err = 1'b0;
        endcase
    end
endmodule

// File: rtl/instr_enc.sv
// Two-stage pipelined RV32I instruction encoder (inverse of imm_gen).
// Ports: clk, rst (async, active high), bus (instr_enc_if.slave handshake +
// fields + encoded word), err_count (saturating count of errored words
// delivered). Build macro INSTR_ENC_RANGE_CHECK_EN adds immediate range
// checking; without it only an invalid fmt raises out_err.
module instr_enc
    import imm_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_enc_if.slave           bus,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam int STAGES = 2;

    logic [STAGES:1] vld_pipe;
    enc_req_t        s1;
    logic            adv;
    logic [31:0]     enc_instr;
    logic            fmt_err;
    logic            range_err;

    // Both stages move as one; a held output word freezes the whole pipe.
    assign adv          = !vld_pipe[2] || bus.out_ready;
    assign bus.in_ready = adv && !rst;
    assign bus.out_valid = vld_pipe[2];

    always_comb begin
        enc_instr = '0;
        fmt_err   = 1'b0;
        case (s1.fmt)
            FMT_I: enc_instr = {s1.imm[11:0], s1.rs1, s1.funct3, s1.rd, s1.opcode};
            FMT_S: enc_instr = {s1.imm[11:5], s1.rs2, s1.rs1, s1.funct3,
                                s1.imm[4:0], s1.opcode};
            FMT_B: enc_instr = {s1.imm[12], s1.imm[10:5], s1.rs2, s1.rs1, s1.funct3,
                                s1.imm[4:1], s1.imm[11], s1.opcode};
            FMT_U: enc_instr = {s1.imm[31:12], s1.rd, s1.opcode};
            FMT_J: enc_instr = {s1.imm[20], s1.imm[10:1], s1.imm[11], s1.imm[19:12],
                                s1.rd, s1.opcode};
            FMT_R: enc_instr = {s1.funct7, s1.rs2, s1.rs1, s1.funct3, s1.rd, s1.opcode};
            default: fmt_err = 1'b1;
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    imm_range_chk u_range_chk (
        .fmt       (s1.fmt),
        .imm       (s1.imm),
        .range_err (range_err)
    );
`else
    assign range_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe      <= '0;
            s1            <= '0;
            bus.out_instr <= '0;
            bus.out_err   <= 1'b0;
            err_count     <= '0;
        end else begin
            if (adv) begin
                // in_ready equals adv outside reset, so in_valid is the transfer.
                vld_pipe <= {vld_pipe[1], bus.in_valid};
                if (bus.in_valid) begin
                    s1 <= '{fmt: bus.fmt, opcode: bus.opcode, rd: bus.rd,
                            rs1: bus.rs1, rs2: bus.rs2, funct3: bus.funct3,
                            funct7: bus.funct7, imm: bus.imm};
                end
                if (vld_pipe[1]) begin
                    bus.out_instr <= enc_instr;
                    bus.out_err   <= fmt_err || range_err;
                end
            end
            if (bus.out_valid && bus.out_ready && bus.out_err && (err_count != '1))
                err_count <= err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_enc.sv
// Self-checking bench for instr_enc: directed vectors, range/format errors,
// backpressure, mid-flight reset and a randomized encode/decode round trip
// against a field-level reference model.
module tb_instr_enc;
    import imm_pkg::*;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    localparam bit RANGE_ON = 1'b1;
`else
    localparam bit RANGE_ON = 1'b0;
`endif

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } w_t;

    logic        clk;
    logic        rst;
    logic [15:0] err_count;
    instr_enc_if bus ();

    instr_enc #(.ERR_CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_count (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_enc(input w_t w);
        case (w.fmt)
            3'd0: return {w.imm[11:0], w.rs1, w.funct3, w.rd, w.opcode};
            3'd1: return {w.imm[11:5], w.rs2, w.rs1, w.funct3, w.imm[4:0], w.opcode};
            3'd2: return {w.imm[12], w.imm[10:5], w.rs2, w.rs1, w.funct3, w.imm[4:1],
                          w.imm[11], w.opcode};
            3'd3: return {w.imm[31:12], w.rd, w.opcode};
            3'd4: return {w.imm[20], w.imm[10:1], w.imm[11], w.imm[19:12], w.rd, w.opcode};
            3'd5: return {w.funct7, w.rs2, w.rs1, w.funct3, w.rd, w.opcode};
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit ref_err(input w_t w);
        int s;
        bit bad_fmt, range_bad;
        s = $signed(w.imm);
        bad_fmt = (w.fmt > 3'd5);
        range_bad = 1'b0;
        case (w.fmt)
            3'd0, 3'd1: range_bad = (s < -2048) || (s > 2047);
            3'd2:       range_bad = (s < -4096) || (s > 4094) || (s % 2 != 0);
            3'd3:       range_bad = (w.imm % 4096) != 0;
            3'd4:       range_bad = (s < -(1 << 20)) || (s > (1 << 20) - 2) || (s % 2 != 0);
            default:    range_bad = 1'b0;
        endcase
        return bad_fmt || (RANGE_ON && range_bad);
    endfunction

    // imm_gen-style decode of the immediate from an encoded word.
    function automatic logic [31:0] ref_dec(input logic [2:0] f, input logic [31:0] i);
        case (f)
            3'd0: return {{20{i[31]}}, i[31:20]};
            3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3: return {i[31:12], 12'h000};
            3'd4: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic w_t rand_word(input logic [2:0] f);
        w_t w;
        int v;
        logic [31:0] r;
        w.fmt    = f;
        w.opcode = 7'($urandom());
        w.rd     = 5'($urandom());
        w.rs1    = 5'($urandom());
        w.rs2    = 5'($urandom());
        w.funct3 = 3'($urandom());
        w.funct7 = 7'($urandom());
        r = $urandom();
        case (f)
            3'd0, 3'd1: v = int'($urandom_range(0, 4095)) - 2048;
            3'd2:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
            3'd3:       v = int'({r[31:12], 12'h000});
            3'd4:       v = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
            default:    v = int'(r);
        endcase
        w.imm = v;
        return w;
    endfunction

    function automatic w_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [2:0] f3, input logic [31:0] imm);
        w_t w;
        w.fmt = f; w.opcode = op; w.rd = rd; w.rs1 = rs1; w.rs2 = 5'd0;
        w.funct3 = f3; w.funct7 = 7'd0; w.imm = imm;
        return w;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive(input w_t w);
        bus.fmt = w.fmt; bus.opcode = w.opcode; bus.rd = w.rd; bus.rs1 = w.rs1;
        bus.rs2 = w.rs2; bus.funct3 = w.funct3; bus.funct7 = w.funct7; bus.imm = w.imm;
    endtask

    // Push one word with out_ready high; return the first valid output and its latency.
    task automatic single(input w_t w, output logic [31:0] o_instr, output logic o_err,
                          output int lat);
        int n;
        @(negedge clk);
        drive(w);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        n = 0;
        #1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk); lat++;
        end
        o_instr = bus.out_instr;
        o_err = bus.out_err;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        drive(mk(3'd0, 7'd0, 5'd0, 5'd0, 3'd0, 32'd0));
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || bus.out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b instr=%h err=%b, want 0/0/0",
                     bus.out_valid, bus.out_instr, bus.out_err);
        end
        checks++;
        if (err_count !== 16'd0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt_ready: err_count=%0d in_ready=%b, want 0/0",
                     err_count, bus.in_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: in_ready=%b want 1", bus.in_ready);
        end
    endtask

    task automatic test_directed;
        w_t v[3];
        logic [31:0] want[3];
        logic [31:0] got;
        logic e;
        int lat;
        v[0] = mk(3'd0, OP_IMM, 5'd7, 5'd10, 3'd2, 32'h0000_07F3); want[0] = 32'h7F35_2393;
        v[1] = mk(3'd4, JAL,    5'd1, 5'd0,  3'd0, 32'hFFFF_FFFC); want[1] = 32'hFFDF_F0EF;
        v[2] = mk(3'd3, LUI,    5'd5, 5'd0,  3'd0, 32'h1234_5000); want[2] = 32'h1234_52B7;
        for (int k = 0; k < 3; k++) begin
            single(v[k], got, e, lat);
            checks++;
            if (got !== want[k] || e !== 1'b0) begin
                errors++;
                $display("FAIL directed_%0d: instr=%h err=%b, want %h/0", k, got, e, want[k]);
            end
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL latency_%0d: got %0d cycles want 2", k, lat);
            end
        end
    endtask

    task automatic test_range;
        w_t v[3];
        logic [31:0] got;
        logic e;
        int lat;
        v[0] = mk(3'd2, BRANCH, 5'd0, 5'd3, 3'd0, 32'd3);
        v[1] = mk(3'd0, OP_IMM, 5'd2, 5'd4, 3'd0, 32'd2048);
        v[2] = mk(3'd7, OP,     5'd9, 5'd9, 3'd7, 32'h0000_0123);
        for (int k = 0; k < 3; k++) begin
            single(v[k], got, e, lat);
            checks++;
            if (got !== ref_enc(v[k]) || e !== ref_err(v[k])) begin
                errors++;
                $display("FAIL range_%0d: instr=%h err=%b, want %h/%b",
                         k, got, e, ref_enc(v[k]), ref_err(v[k]));
            end
            if (ref_err(v[k])) exp_cnt++;
            @(negedge clk);
            checks++;
            if (err_count !== 16'(exp_cnt)) begin
                errors++;
                $display("FAIL err_count_%0d: got %0d want %0d", k, err_count, exp_cnt);
            end
        end
        // Invalid fmt must give a zero word and error regardless of build.
        checks++;
        if (got !== 32'h0 || e !== 1'b1) begin
            errors++;
            $display("FAIL bad_fmt: instr=%h err=%b, want 0/1", got, e);
        end
    endtask

    task automatic test_backpressure;
        w_t w[3];
        logic [31:0] held;
        int acc, got;
        for (int i = 0; i < 3; i++) w[i] = rand_word(3'($urandom_range(0, 5)));
        held = 32'h0;
        acc = 0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            drive(w[acc]);
            bus.in_valid = 1'b1;
            #1;
            if (c == 2) held = bus.out_instr;
            if (c == 3) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_instr !== held) begin
                    errors++;
                    $display("FAIL stall_stable: valid=%b instr=%h, want 1/%h",
                             bus.out_valid, bus.out_instr, held);
                end
            end
            if (bus.in_ready) acc++;
        end
        checks++;
        if (acc !== 2 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accepts: accepted=%0d in_ready=%b, want 2/0", acc, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        #1;
        got = 0;
        for (int n = 0; n < 20 && got < 3; n++) begin
            if (n > 0) begin
                @(negedge clk);
                bus.in_valid = (acc < 3);
                if (acc < 3) drive(w[acc]);
                #1;
            end
            if (bus.in_valid && bus.in_ready) acc++;
            if (bus.out_valid) begin
                checks++;
                if (bus.out_instr !== ref_enc(w[got]) || bus.out_err !== ref_err(w[got])) begin
                    errors++;
                    $display("FAIL bp_order_%0d: instr=%h err=%b, want %h/%b", got,
                             bus.out_instr, bus.out_err, ref_enc(w[got]), ref_err(w[got]));
                end
                if (ref_err(w[got])) exp_cnt++;
                got++;
            end
        end
        checks++;
        if (got !== 3) begin
            errors++;
            $display("FAIL bp_drain: got %0d words want 3", got);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_midflight;
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clk);
            drive(rand_word(3'd0));
            bus.in_valid = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midflight_pre: out_valid=%b want 1", bus.out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL midflight_rst: valid=%b in_ready=%b err_count=%0d, want 0/0/0",
                     bus.out_valid, bus.in_ready, err_count);
        end
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_word_%0d: out_valid=%b want 0", c, bus.out_valid);
            end
        end
    endtask

    task automatic test_roundtrip;
        localparam int N = 1000;
        w_t q[$];
        w_t nw, e;
        int sent, rcvd, cyc;
        sent = 0; rcvd = 0; cyc = 0;
        nw = rand_word(3'd0);
        while ((sent < N || rcvd < N) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rt_spurious: instr=%h with nothing outstanding", bus.out_instr);
                end else begin
                    e = q.pop_front();
                    if (bus.out_instr !== ref_enc(e) || bus.out_err !== ref_err(e)) begin
                        errors++;
                        $display("FAIL rt_word_%0d: fmt=%0d imm=%h instr=%h err=%b, want %h/%b",
                                 rcvd, e.fmt, e.imm, bus.out_instr, bus.out_err,
                                 ref_enc(e), ref_err(e));
                    end
                    if (e.fmt != 3'd5) begin
                        checks++;
                        if (ref_dec(e.fmt, bus.out_instr) !== e.imm) begin
                            errors++;
                            $display("FAIL rt_decode_%0d: fmt=%0d decoded=%h, want %h",
                                     rcvd, e.fmt, ref_dec(e.fmt, bus.out_instr), e.imm);
                        end
                    end
                    if (ref_err(e)) exp_cnt++;
                    rcvd++;
                end
            end
            if (sent < N && $urandom_range(0, 3) != 0) begin
                nw = rand_word(3'($urandom_range(0, 5)));
                drive(nw);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(nw);
                sent++;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (rcvd !== N) begin
            errors++;
            $display("FAIL rt_count: received %0d words want %0d (timeout)", rcvd, N);
        end
        @(negedge clk);
        checks++;
        if (err_count !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL rt_err_count: got %0d want %0d", err_count, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_range();
        test_backpressure();
        test_reset_midflight();
        test_roundtrip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
